// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - D-stage hazard scoreboard with forward select and MDU interlock
module hazard_scoreboard #(
   parameter int NSTAGE   = 3,
   parameter int TW       = 3,
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          D_valid,
   input  logic [4:0]    D_rs,
   input  logic [4:0]    D_rt,
   input  logic [TW-1:0] D_Tuse_rs,
   input  logic [TW-1:0] D_Tuse_rt,
   input  logic          D_RegWr,
   input  logic [4:0]    D_RegAddr,
   input  logic [TW-1:0] D_Tnew,
   input  logic          D_mdu_start,
   input  logic          D_mdu_div,
   input  logic          D_mdu_use,
   output logic          Stall,
   output logic [2:0]    fwd_rs_sel,
   output logic [2:0]    fwd_rt_sel,
   output logic          mdu_busy
);

   localparam int CW = $clog2(DIV_CYC + 1);

   // Scoreboard: stage 0 = E, stage 1 = M, ...
   logic [NSTAGE-1:0]         wr_q, wr_d;
   logic [NSTAGE-1:0][4:0]    addr_q, addr_d;
   logic [NSTAGE-1:0][TW-1:0] tnew_q, tnew_d;
   logic [CW-1:0]             cnt_q, cnt_d;

   logic raw_haz;
   logic issue;

   // RAW hazard detection across all tracked stages, plus the MDU interlock
   always_comb begin
      raw_haz = 1'b0;
      for (int i = 0; i < NSTAGE; i++) begin
         if (wr_q[i] && addr_q[i] == D_rs && D_rs != 5'd0 && tnew_q[i] > D_Tuse_rs)
            raw_haz = 1'b1;
         if (wr_q[i] && addr_q[i] == D_rt && D_rt != 5'd0 && tnew_q[i] > D_Tuse_rt)
            raw_haz = 1'b1;
      end
      mdu_busy = (cnt_q != '0);
      Stall    = D_valid && (raw_haz || (D_mdu_use && mdu_busy));
      issue    = D_valid && !Stall;
   end

   // Forward select: youngest matching stage wins; forward only once its result is ready
   always_comb begin
      logic found_rs;
      logic found_rt;
      found_rs   = 1'b0;
      found_rt   = 1'b0;
      fwd_rs_sel = 3'd0;
      fwd_rt_sel = 3'd0;
      for (int i = 0; i < NSTAGE; i++) begin
         if (!found_rs && wr_q[i] && addr_q[i] == D_rs && D_rs != 5'd0) begin
            found_rs   = 1'b1;
            fwd_rs_sel = (tnew_q[i] == '0) ? 3'(i + 1) : 3'd0;
         end
         if (!found_rt && wr_q[i] && addr_q[i] == D_rt && D_rt != 5'd0) begin
            found_rt   = 1'b1;
            fwd_rt_sel = (tnew_q[i] == '0) ? 3'(i + 1) : 3'd0;
         end
      end
   end

   // Scoreboard advance: load stage 0 from D (or a bubble), shift the rest with saturating tnew
   always_comb begin
      wr_d   = '0;
      addr_d = '0;
      tnew_d = '0;
      if (issue) begin
         wr_d[0]   = D_RegWr;
         addr_d[0] = D_RegAddr;
         tnew_d[0] = D_Tnew;
      end
      for (int i = 1; i < NSTAGE; i++) begin
         wr_d[i]   = wr_q[i-1];
         addr_d[i] = addr_q[i-1];
         tnew_d[i] = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - 1'b1;
      end
   end

   // MDU busy counter: loads when a start instruction leaves D, otherwise counts down to 0
   always_comb begin
      cnt_d = cnt_q;
      if (issue && D_mdu_start)
         cnt_d = D_mdu_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q   <= '0;
         addr_q <= '0;
         tnew_q <= '0;
         cnt_q  <= '0;
      end else begin
         wr_q   <= wr_d;
         addr_q <= addr_d;
         tnew_q <= tnew_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

   localparam int NSTAGE   = 3;
   localparam int TW       = 3;
   localparam int MULT_CYC = 5;
   localparam int DIV_CYC  = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          D_valid;
   logic [4:0]    D_rs, D_rt, D_RegAddr;
   logic [TW-1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
   logic          D_RegWr, D_mdu_start, D_mdu_div, D_mdu_use;
   logic          Stall, mdu_busy;
   logic [2:0]    fwd_rs_sel, fwd_rt_sel;

   hazard_scoreboard #(.NSTAGE(NSTAGE), .TW(TW), .MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .D_valid(D_valid), .D_rs(D_rs), .D_rt(D_rt),
      .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .D_RegWr(D_RegWr),
      .D_RegAddr(D_RegAddr), .D_Tnew(D_Tnew), .D_mdu_start(D_mdu_start),
      .D_mdu_div(D_mdu_div), .D_mdu_use(D_mdu_use), .Stall(Stall),
      .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .mdu_busy(mdu_busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: list of instructions that entered E (youngest first), each with the
   // Tnew it carried on entry; current Tnew is that value minus its age, floored at 0.
   typedef struct {
      bit wr;
      int addr;
      int tn;
   } ent_t;
   ent_t pq[$];
   int   cyc      = 0;
   int   busy_end = -1;
   int   e_stall, e_rs, e_rt, e_busy;

   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic model_clear();
      ent_t b;
      b.wr = 0; b.addr = 0; b.tn = 0;
      pq.delete();
      for (int i = 0; i < NSTAGE; i++) pq.push_back(b);
      busy_end = -1;
   endtask

   task automatic model_eval();
      bit frs, frt;
      int tn;
      bit mrs, mrt;
      frs = 0; frt = 0;
      e_stall = 0; e_rs = 0; e_rt = 0;
      e_busy = (cyc <= busy_end) ? 1 : 0;
      for (int i = 0; i < NSTAGE; i++) begin
         tn  = (pq[i].tn > i) ? pq[i].tn - i : 0;
         mrs = pq[i].wr && pq[i].addr == int'(D_rs) && D_rs != 0;
         mrt = pq[i].wr && pq[i].addr == int'(D_rt) && D_rt != 0;
         if (D_valid && mrs && tn > int'(D_Tuse_rs)) e_stall = 1;
         if (D_valid && mrt && tn > int'(D_Tuse_rt)) e_stall = 1;
         if (mrs && !frs) begin frs = 1; e_rs = (tn == 0) ? i + 1 : 0; end
         if (mrt && !frt) begin frt = 1; e_rt = (tn == 0) ? i + 1 : 0; end
      end
      if (D_valid && D_mdu_use && e_busy != 0) e_stall = 1;
   endtask

   // One pipeline cycle: check outputs mid-cycle against the model (and optional directed
   // expectations), then let the edge happen and advance the model.
   task automatic tick(string tag, int xs = -1, int xr = -1);
      ent_t e;
      @(negedge clk);
      model_eval();
      chk({tag, ".stall"}, 8'(Stall), 8'(e_stall));
      chk({tag, ".fwd_rs"}, 8'(fwd_rs_sel), 8'(e_rs));
      chk({tag, ".fwd_rt"}, 8'(fwd_rt_sel), 8'(e_rt));
      chk({tag, ".busy"}, 8'(mdu_busy), 8'(e_busy));
      if (xs >= 0) chk({tag, ".dir_stall"}, 8'(Stall), 8'(xs));
      if (xr >= 0) chk({tag, ".dir_fwd_rs"}, 8'(fwd_rs_sel), 8'(xr));
      @(posedge clk);
      if (D_valid && e_stall == 0) begin
         e.wr = D_RegWr; e.addr = int'(D_RegAddr); e.tn = int'(D_Tnew);
         if (D_mdu_start) busy_end = cyc + (D_mdu_div ? DIV_CYC : MULT_CYC);
      end else begin
         e.wr = 0; e.addr = 0; e.tn = 0;
      end
      pq.push_front(e);
      void'(pq.pop_back());
      cyc++;
      #1;
   endtask

   task automatic set_d(bit v, int rs, int tur, int rt, int tut, bit wr, int ra, int tn,
                        bit st = 0, bit dv = 0, bit use_hl = 0);
      D_valid = v; D_rs = 5'(rs); D_Tuse_rs = TW'(tur); D_rt = 5'(rt); D_Tuse_rt = TW'(tut);
      D_RegWr = wr; D_RegAddr = 5'(ra); D_Tnew = TW'(tn);
      D_mdu_start = st; D_mdu_div = dv; D_mdu_use = use_hl | st;
   endtask

   initial begin
      rst_n = 1'b0;
      set_d(1, 3, 0, 3, 0, 1, 3, 2, 0, 0, 1);
      model_clear();
      #12;
      chk("rst.stall", 8'(Stall), 8'd0);
      chk("rst.fwd_rs", 8'(fwd_rs_sel), 8'd0);
      chk("rst.fwd_rt", 8'(fwd_rt_sel), 8'd0);
      chk("rst.busy", 8'(mdu_busy), 8'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_d(0, 0, 0, 0, 0, 0, 0, 0);
      tick("idle", 0, 0);

      // Load-use: lw $9 then add rs=9 Tuse=1
      set_d(1, 0, 0, 0, 0, 1, 9, 2); tick("lu_lw", 0);
      set_d(1, 9, 1, 0, 0, 1, 10, 1); tick("lu_add0", 1);
      tick("lu_add1", 0, 0);
      set_d(0, 0, 0, 0, 0, 0, 0, 0); tick("gap0");

      // Branch after ALU op
      set_d(1, 0, 0, 0, 0, 1, 8, 1); tick("br_addu", 0);
      set_d(1, 8, 0, 8, 0, 0, 0, 0); tick("br_beq0", 1);
      tick("br_beq1", 0, 2);
      set_d(0, 0, 0, 0, 0, 0, 0, 0); tick("gap1"); tick("gap2");

      // Register 0 never hazards or forwards
      set_d(1, 0, 0, 0, 0, 1, 0, 2); tick("r0_lw", 0);
      set_d(1, 0, 0, 0, 0, 1, 4, 1); tick("r0_use", 0, 0);

      // D_valid=0 with matching fields loads a bubble
      set_d(1, 0, 0, 0, 0, 1, 9, 2); tick("bub_lw", 0);
      set_d(0, 9, 0, 9, 0, 1, 9, 3); tick("bub_inv", 0);
      set_d(1, 9, 1, 0, 0, 0, 0, 0); tick("bub_use", 0, 0);
      set_d(0, 0, 0, 0, 0, 0, 0, 0); tick("gap3"); tick("gap4");

      // Youngest match wins
      set_d(1, 0, 0, 0, 0, 1, 5, 0); tick("yw_a", 0);
      set_d(1, 0, 0, 0, 0, 1, 5, 0); tick("yw_b", 0);
      set_d(1, 5, 1, 5, 1, 1, 6, 1); tick("yw_use", 0, 1);
      set_d(0, 0, 0, 0, 0, 0, 0, 0); tick("gap5");

      // mult then mflo: 5 stalled cycles, leaves on the 6th
      set_d(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick("mul_st", 0);
      set_d(1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 1);
      for (int i = 0; i < MULT_CYC; i++) tick("mul_wait", 1);
      tick("mul_go", 0);
      set_d(0, 0, 0, 0, 0, 0, 0, 0); tick("gap6");

      // div then mflo: 10 stalled cycles
      set_d(1, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick("div_st", 0);
      set_d(1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 1);
      for (int i = 0; i < DIV_CYC; i++) tick("div_wait", 1);
      tick("div_go", 0);
      set_d(0, 0, 0, 0, 0, 0, 0, 0); tick("gap7");

      // Reset in the middle of a div interlock (counter at 7)
      set_d(1, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick("rdiv_st", 0);
      set_d(1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 1);
      for (int i = 0; i < 3; i++) tick("rdiv_wait", 1);
      #2;
      chk("rmid.stall_pre", 8'(Stall), 8'd1);
      chk("rmid.busy_pre", 8'(mdu_busy), 8'd1);
      rst_n = 1'b0;
      #1;
      chk("rmid.stall", 8'(Stall), 8'd0);
      chk("rmid.busy", 8'(mdu_busy), 8'd0);
      chk("rmid.fwd_rs", 8'(fwd_rs_sel), 8'd0);
      chk("rmid.fwd_rt", 8'(fwd_rt_sel), 8'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_clear();
      tick("rpost_mflo", 0);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         set_d($urandom_range(0, 3) != 0,
               $urandom_range(0, 7), $urandom_range(0, 3),
               $urandom_range(0, 7), $urandom_range(0, 3),
               $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 3),
               $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 5) == 0);
         tick("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
